load_store_unit: RTL
====================

# load_store_unit

- Sits between the core's execute stage and the word-addressed data memory (256 x 32-bit, byte-masked write, combinational read).
- Takes byte-addressed RV32 load/store requests and turns each into one or two word accesses. It generates the byte write masks and lane-shifts the store data.
- Misaligned accesses that cross a word boundary are split in two; the load halves are merged and sign/zero-extended.
- Each request completes with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 10, byte-address width (word address = ADDR_W-2 = 8 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE; request accepted on a rising edge with req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal funct3; valid with rsp_valid
- mem_load  out  1  memory read enable
- mem_store  out  1  memory write enable; write occurs at the next rising edge
- mem_address  out  8  word address
- mem_wdata  out  32  lane-aligned write data
- mem_masking  out  4  byte write enables; bit i covers bits [8i+7:8i]
- mem_rdata  in  32  combinational read data for mem_address

## Operation
**FSM states:** IDLE, ACC0, ACC1, RESP.

**Transitions:**
- IDLE -> ACC0 on accept. Latches we, funct3, addr, wdata.
- IDLE -> RESP on accept of an illegal funct3. No memory access is made.
- ACC0 -> ACC1 if split, else ACC0 -> RESP.
- ACC1 -> RESP.
- RESP -> IDLE.

**Access shape:**
- Size s = 1/2/4 bytes. Offset o = addr[1:0].
- 8-bit mask m = ((1<<s)-1) << o.
- split = (m[7:4] != 0).

**ACC0:**
- mem_address = addr[ADDR_W-1:2].
- Store: mem_store=1, mem_masking = m[3:0], mem_wdata = low word of ({32'b0, wdata} << 8o).
- Load: mem_load=1, mem_masking = 0. mem_rdata is captured into the lo register at the end of the cycle.

**ACC1:**
- mem_address = word address + 1, modulo 256 (255 wraps to 0).
- Store: mem_store=1, mem_masking = m[7:4], mem_wdata = high word of the shifted data.
- Load: mem_load=1, mem_masking = 0. mem_rdata is captured into the hi register.

**RESP:**
- rsp_valid = 1.
- Load result: r = ({hi, lo} >> 8o), low s bytes kept. Sign-extended for LB/LH, zero-extended for LBU/LHU.
- hi is 0 when there is no split.

**Illegal funct3:**
- Loads: 011, 110, 111. Stores: 011 through 111.
- Result: rsp_err = 1, rsp_rdata = 0.

**Idle outputs:** outside ACC0/ACC1, all mem_* outputs are 0.

**Reset:**
- On assertion at any time, state goes to IDLE and every output register clears to 0. Any in-flight request is dropped with no response.
- A partially issued split store stays partially written; the core is responsible for replay.

## Timing
- Accept at edge n. ACC0 spans cycle n..n+1.
- Non-split: rsp_valid high in cycle n+1..n+2. Next request can be accepted at edge n+2.
- Split: ACC1 spans n+1..n+2; rsp_valid high in n+2..n+3.
- Illegal funct3: rsp_valid high in n..n+1 (RESP directly).
- req_ready is combinational = (state == IDLE) and reads 1 immediately after reset release.
- Request inputs may change freely after acceptance.
- rsp_valid is never held; there is no back-pressure on the response side.
- All mem_* outputs and rsp_* are driven from registered state and latched fields only. There is no combinational path from req_* to mem_*.

## Structure
- lsu_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - the state enum
  - size-decode function funct3 -> byte count, with an illegal flag
- Sub-module lsu_align (combinational), given funct3, offset, wdata, lo and hi, produces:
  - the 8-bit mask and split flag
  - the 64-bit shifted store data
  - the extended load result
- FSM and registers live in load_store_unit.

## Test plan
- SW addr 0x010, wdata 0xDEADBEEF -> one access: address 4, masking 1111, wdata 0xDEADBEEF. rsp_valid at n+1, rsp_err 0.
- SB addr 0x013, wdata 0x000000A5 -> masking 1000, wdata 0xA5000000, address 4. Then LB at 0x013 returns 0xFFFFFFA5 and LBU returns 0x000000A5.
- SW addr 0x011, wdata 0x11223344:
  - first access: address 4, masking 1110, wdata 0x22334400
  - second access: address 5, masking 0001, wdata 0x00000011
  - LW at 0x011 returns 0x11223344, rsp_valid at n+2
- LH addr 0x3FF, with word 255 = 0x80xxxxxx and word 0 = 0xxxxxxx7F:
  - accesses go to word addresses 255 then 0 (wrap)
  - rsp_rdata = 0x00007F80
- req_funct3 = 011 on a load -> no mem_load pulse; rsp_valid at n with rsp_err 1 and rsp_rdata 0.
- rst_n low during ACC1 of a split store -> no ACC1 write and no rsp_valid. req_ready = 1 after release, and a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit. It holds the RV32
//               funct3 encodings, the FSM state type and the funct3-to-size
//               decoder with its illegal-encoding flag.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Load encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   // Store encodings (these share codes with the signed loads)
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic       illegal;
      logic [2:0] nbytes;   // 1, 2 or 4; 0 when illegal
   } lsu_size_t;

   // Access size in bytes for a funct3. LBU/LHU codes have no store
   // counterpart, so they are illegal when we = 1.
   function automatic lsu_size_t size_decode(input logic we, input logic [2:0] funct3);
      lsu_size_t r;
      r.illegal = 1'b0;
      r.nbytes  = 3'd0;
      case (funct3)
         3'b000: r.nbytes = 3'd1;
         3'b001: r.nbytes = 3'd2;
         3'b010: r.nbytes = 3'd4;
         3'b100: begin
            if (we) r.illegal = 1'b1;
            else    r.nbytes  = 3'd1;
         end
         3'b101: begin
            if (we) r.illegal = 1'b1;
            else    r.nbytes  = 3'd2;
         end
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
      lsu_size_t r;
      r = size_decode(we, funct3);
      return r.illegal;
   endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane alignment for the load/store unit.
//               Builds the 8-bit two-word byte mask, detects word-crossing
//               accesses, lane-shifts store data across a 64-bit window and
//               merges/extends the two load words into the final result.
// Ports       : we_i      - 1 = store, 0 = load
//               funct3_i  - access encoding
//               offset_i  - byte offset within the first word
//               wdata_i   - right-justified store data
//               lo_i/hi_i - first/second loaded word (hi is 0 if no split)
//               mask_o    - byte mask over {word+1, word}
//               split_o   - access touches the second word
//               wshift_o  - store data shifted into byte lanes
//               rdata_o   - sign/zero-extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] lo_i,
   input  logic [31:0] hi_i,
   output logic [7:0]  mask_o,
   output logic        split_o,
   output logic [63:0] wshift_o,
   output logic [31:0] rdata_o
);

   lsu_size_t   w_size;
   logic [7:0]  w_base_mask;
   logic [5:0]  w_shamt;
   logic [31:0] w_merged;

   assign w_size  = size_decode(we_i, funct3_i);
   assign w_shamt = {offset_i, 3'b000};

   always_comb begin
      w_base_mask = 8'h00;
      case (w_size.nbytes)
         3'd1:    w_base_mask = 8'h01;
         3'd2:    w_base_mask = 8'h03;
         3'd4:    w_base_mask = 8'h0F;
         default: w_base_mask = 8'h00;
      endcase
   end

   assign mask_o   = w_size.illegal ? 8'h00 : (w_base_mask << offset_i);
   assign split_o  = |mask_o[7:4];
   assign wshift_o = {32'h0, wdata_i} << w_shamt;

   // Only the low word of the shifted pair carries the requested bytes.
   assign w_merged = 32'({hi_i, lo_i} >> w_shamt);

   always_comb begin
      rdata_o = 32'h0;
      if (!w_size.illegal) begin
         case (funct3_i)
            F3_LB:   rdata_o = {{24{w_merged[7]}},  w_merged[7:0]};
            F3_LH:   rdata_o = {{16{w_merged[15]}}, w_merged[15:0]};
            F3_LW:   rdata_o = w_merged;
            F3_LBU:  rdata_o = {24'h0, w_merged[7:0]};
            F3_LHU:  rdata_o = {16'h0, w_merged[15:0]};
            default: rdata_o = 32'h0;
         endcase
      end
   end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Converts byte-addressed RV32 load/store requests into one or
//               two accesses on a word-addressed, byte-masked data memory.
//               Word-crossing accesses are split; load halves are merged and
//               extended. Every accepted request ends with a one-cycle
//               response pulse.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               req_*            - request handshake and fields
//               rsp_*            - completion pulse, load data, error flag
//               mem_*            - data memory interface (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_load,
   output logic              mem_store,
   output logic [ADDR_W-3:0] mem_address,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_masking,
   input  logic [31:0]       mem_rdata
);

   localparam int WA_W = ADDR_W - 2;

   lsu_state_e        state_q, state_d;
   logic              we_q,    we_d;
   logic [2:0]        f3_q,    f3_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       lo_q,    lo_d;
   logic [31:0]       hi_q,    hi_d;
   logic              err_q,   err_d;

   logic [7:0]        w_mask;
   logic              w_split;
   logic [63:0]       w_wshift;
   logic [31:0]       w_ldata;
   logic [WA_W-1:0]   w_word;

   // Alignment works only from latched fields, so no req_* reaches mem_*.
   lsu_align u_align (
      .we_i     (we_q),
      .funct3_i (f3_q),
      .offset_i (addr_q[1:0]),
      .wdata_i  (wdata_q),
      .lo_i     (lo_q),
      .hi_i     (hi_q),
      .mask_o   (w_mask),
      .split_o  (w_split),
      .wshift_o (w_wshift),
      .rdata_o  (w_ldata)
   );

   assign w_word = addr_q[ADDR_W-1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         lo_q    <= 32'h0;
         hi_q    <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      err_d       = err_q;

      req_ready   = (state_q == ST_IDLE);
      rsp_valid   = 1'b0;
      rsp_rdata   = 32'h0;
      rsp_err     = 1'b0;
      mem_load    = 1'b0;
      mem_store   = 1'b0;
      mem_address = '0;
      mem_wdata   = 32'h0;
      mem_masking = 4'h0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               lo_d    = 32'h0;
               // hi must read as zero for non-split loads
               hi_d    = 32'h0;
               if (funct3_illegal(req_we, req_funct3)) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_ACC0;
               end
            end
         end

         ST_ACC0: begin
            mem_address = w_word;
            if (we_q) begin
               mem_store   = 1'b1;
               mem_masking = w_mask[3:0];
               mem_wdata   = w_wshift[31:0];
            end else begin
               mem_load = 1'b1;
               lo_d     = mem_rdata;
            end
            state_d = w_split ? ST_ACC1 : ST_RESP;
         end

         ST_ACC1: begin
            // Word address wraps naturally at the top of memory.
            mem_address = w_word + WA_W'(1);
            if (we_q) begin
               mem_store   = 1'b1;
               mem_masking = w_mask[7:4];
               mem_wdata   = w_wshift[63:32];
            end else begin
               mem_load = 1'b1;
               hi_d     = mem_rdata;
            end
            state_d = ST_RESP;
         end

         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (we_q || err_q) ? 32'h0 : w_ldata;
            state_d   = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule : load_store_unit
`default_nettype wire
